// File: rtl/turbo_itl_pcore.sv
// Turbo interleaver buffer for the HPGP RX path: captures one physical block of soft samples
// and drains it NLANE samples per beat in interleaved or de-interleaved order.
module turbo_itl_pcore #(
    parameter int unsigned SW      = 2,
    parameter int unsigned NLANE   = 4,
    parameter int unsigned STEP16  = 9,
    parameter int unsigned STEP136 = 39,
    parameter int unsigned STEP520 = 261
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [1:0]          pb_size,
    input  logic                mod_int_dint,
    input  logic [SW-1:0]       din,
    input  logic                din_vld,
    input  logic                start,
    output logic                in_rdy,
    output logic [NLANE*SW-1:0] dout,
    output logic                dout_vld,
    output logic                dout_last,
    output logic                busy,
    output logic                err
);
    localparam int unsigned AW   = 12;
    localparam int unsigned MAXL = 2080;

    // Per-beat address increments and final beat index for each block size
    localparam logic [AW-1:0] D16  = AW'((NLANE * STEP16) % 64);
    localparam logic [AW-1:0] D136 = AW'((NLANE * STEP136) % 544);
    localparam logic [AW-1:0] D520 = AW'((NLANE * STEP520) % 2080);
    localparam logic [AW-1:0] B16  = AW'(64 / NLANE - 1);
    localparam logic [AW-1:0] B136 = AW'(544 / NLANE - 1);
    localparam logic [AW-1:0] B520 = AW'(2080 / NLANE - 1);

    typedef enum logic [1:0] {StIdle, StFill, StFull, StDrain} state_e;

    state_e              state_q, state_d;
    logic [1:0]          size_q;
    logic                mode_q;
    logic [AW-1:0]       cnt_q, perm_q, beat_q;
    logic                run_q;
    logic [AW-1:0]       addr_q [NLANE];
    logic [AW-1:0]       lane_init [NLANE];
    logic [NLANE*SW-1:0] dout_q;
    logic                vld_q, last_q, err_q;
    logic [SW-1:0]       mem [MAXL];

    logic [AW-1:0] len, step, lane_inc, last_beat, in_len, in_step, wr_addr;
    logic          wr_en, latch, err_d;

    function automatic logic [AW-1:0] len_of(input logic [1:0] sz);
        case (sz)
            2'd0:    return AW'(64);
            2'd1:    return AW'(544);
            default: return AW'(2080);
        endcase
    endfunction

    function automatic logic [AW-1:0] step_of(input logic [1:0] sz);
        case (sz)
            2'd0:    return AW'(STEP16);
            2'd1:    return AW'(STEP136);
            default: return AW'(STEP520);
        endcase
    endfunction

    // Modular add with a single conditional subtract; both operands are already < l
    function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic [AW-1:0] l);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, l}) s = s - {1'b0, l};
        return s[AW-1:0];
    endfunction

    always_comb begin
        len     = len_of(size_q);
        step    = step_of(size_q);
        in_len  = len_of(pb_size);
        in_step = step_of(pb_size);
        case (size_q)
            2'd0: begin
                lane_inc  = mode_q ? D16 : AW'(NLANE);
                last_beat = B16;
            end
            2'd1: begin
                lane_inc  = mode_q ? D136 : AW'(NLANE);
                last_beat = B136;
            end
            default: begin
                lane_inc  = mode_q ? D520 : AW'(NLANE);
                last_beat = B520;
            end
        endcase
    end

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        localparam logic [AW-1:0] I16  = AW'((k * STEP16) % 64);
        localparam logic [AW-1:0] I136 = AW'((k * STEP136) % 544);
        localparam logic [AW-1:0] I520 = AW'((k * STEP520) % 2080);
        assign lane_init[k] = !mode_q         ? AW'(k) :
                              (size_q == 2'd0) ? I16    :
                              (size_q == 2'd1) ? I136   : I520;
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        latch   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = mode_q ? cnt_q : perm_q;
        unique case (state_q)
            StIdle: begin
                if (din_vld) begin
                    if (pb_size == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (din_vld) begin
                    wr_en = 1'b1;
                    if (cnt_q == len - AW'(1)) state_d = StFull;
                end
            end
            StFull: begin
                if (din_vld) err_d = 1'b1;
                if (start) state_d = StDrain;
            end
            StDrain: begin
                if (din_vld) err_d = 1'b1;
                if (run_q && last_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && n_rst) mem[wr_addr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= StIdle;
            size_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            perm_q  <= '0;
            beat_q  <= '0;
            run_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < NLANE; k++) addr_q[k] <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (latch) begin
                size_q <= pb_size;
                mode_q <= mod_int_dint;
                cnt_q  <= AW'(1);
                perm_q <= add_mod('0, in_step, in_len);
            end else if (wr_en) begin
                cnt_q  <= cnt_q + AW'(1);
                perm_q <= add_mod(perm_q, step, len);
            end
            // First DRAIN cycle loads the lane address registers; beats follow back to back
            if (state_q == StDrain) begin
                if (!run_q) begin
                    run_q  <= 1'b1;
                    beat_q <= '0;
                    for (int k = 0; k < NLANE; k++) addr_q[k] <= lane_init[k];
                end else if (!last_q) begin
                    for (int k = 0; k < NLANE; k++) begin
                        dout_q[k*SW +: SW] <= mem[addr_q[k]];
                        addr_q[k]          <= add_mod(addr_q[k], lane_inc, len);
                    end
                    vld_q  <= 1'b1;
                    last_q <= (beat_q == last_beat);
                    beat_q <= beat_q + AW'(1);
                end else begin
                    vld_q  <= 1'b0;
                    last_q <= 1'b0;
                    run_q  <= 1'b0;
                end
            end else begin
                vld_q  <= 1'b0;
                last_q <= 1'b0;
                run_q  <= 1'b0;
            end
        end
    end

    assign in_rdy    = (state_q == StIdle) || (state_q == StFill);
    assign busy      = (state_q != StIdle);
    assign dout      = dout_q;
    assign dout_vld  = vld_q;
    assign dout_last = last_q;
    assign err       = err_q;

endmodule
